// File: rtl/layers_frame_merger.sv
`default_nettype none
// ============================================================================
// Module   : layers_frame_merger
// Purpose  : Round-robin merge of per-layer frame streams into one buffered
//            output stream. Defining LAYERS_FRAME_MERGER_HEADER_EN adds a
//            header word (layer index + 1) in front of every merged frame.
// Revision : 1.0 - initial release
// ============================================================================
module layers_frame_merger #(
  parameter int LAYER_COUNT = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 1024
) (
  input  logic                              clk_core,
  input  logic                              clk_core_rst,
  input  logic [LAYER_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]            s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]            s_axis_tlast,
  output logic [LAYER_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       m_axis_data_count,
  input  logic [LAYER_COUNT-1:0]            cfg_layer_enable,
  output logic [31:0]                       stat_frames_merged,
  output logic                              status_busy
);

  localparam int C_GW = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_CW = C_AW + 1;

  localparam logic [1:0] c_st_idle    = 2'd0;
`ifdef LAYERS_FRAME_MERGER_HEADER_EN
  localparam logic [1:0] c_st_header  = 2'd1;
`endif
  localparam logic [1:0] c_st_payload = 2'd2;

  logic [1:0]            r_state;
  logic [C_GW-1:0]       r_grant;
  logic [C_GW-1:0]       r_last_grant;
  logic                  r_busy;
  logic [31:0]           r_stat;
  logic [C_CW-1:0]       r_count;
  logic [C_AW-1:0]       r_wr_ptr;
  logic [C_AW-1:0]       r_rd_ptr;
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];

  logic [LAYER_COUNT-1:0] w_cand;
  logic                   w_found;
  logic [C_GW-1:0]        w_pick;
  logic [1:0]             w_next_state;
  logic                   w_full;
  logic                   w_hdr_wr;
  logic                   w_accept;
  logic                   w_wr_en;
  logic                   w_rd_en;
  logic [DATA_WIDTH:0]    w_wr_word;
  logic [DATA_WIDTH:0]    w_rd_word;
  logic [DATA_WIDTH-1:0]  w_beat_data;
  logic                   w_beat_last;
  logic                   w_beat_valid;
  logic [DATA_WIDTH-1:0]  w_hdr_data;

  assign w_cand = s_axis_tvalid & cfg_layer_enable;

  // Search starts one past the previous grant; a single subtraction covers the wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= LAYER_COUNT; k++) begin
      logic [C_GW:0] v_idx;
      v_idx = {1'b0, r_last_grant} + (C_GW+1)'(k);
      if (v_idx >= (C_GW+1)'(LAYER_COUNT)) begin
        v_idx = v_idx - (C_GW+1)'(LAYER_COUNT);
      end
      if (!w_found && w_cand[v_idx[C_GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_idx[C_GW-1:0];
      end
    end
  end

  assign w_beat_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_beat_last  = s_axis_tlast[r_grant];
  assign w_beat_valid = s_axis_tvalid[r_grant];
  assign w_hdr_data   = DATA_WIDTH'(r_grant) + DATA_WIDTH'(1);

  assign w_full   = (r_count == C_CW'(FIFO_DEPTH));
  assign w_accept = (r_state == c_st_payload) && !w_full && w_beat_valid;

  always_comb begin
    w_next_state = r_state;
    w_hdr_wr     = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
`ifdef LAYERS_FRAME_MERGER_HEADER_EN
          w_next_state = c_st_header;
`else
          w_next_state = c_st_payload;
`endif
        end
      end
`ifdef LAYERS_FRAME_MERGER_HEADER_EN
      c_st_header: begin
        if (!w_full) begin
          w_hdr_wr     = 1'b1;
          w_next_state = c_st_payload;
        end
      end
`endif
      c_st_payload: begin
        if (w_accept && w_beat_last) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  assign w_wr_en   = w_hdr_wr | w_accept;
  assign w_wr_word = w_hdr_wr ? {1'b0, w_hdr_data} : {w_beat_last, w_beat_data};
  assign w_rd_en   = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      r_state      <= c_st_idle;
      r_grant      <= '0;
      r_last_grant <= C_GW'(LAYER_COUNT - 1);
      r_busy       <= 1'b0;
      r_stat       <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != c_st_idle);
      if ((r_state == c_st_idle) && w_found) begin
        r_grant <= w_pick;
      end
      if (w_accept && w_beat_last) begin
        r_last_grant <= r_grant;
        r_stat       <= r_stat + 32'd1;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + C_CW'(1);
        2'b01:   r_count <= r_count - C_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk_core) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  assign w_rd_word = r_mem[r_rd_ptr];

  // Outputs read as zero while empty so reset leaves a clean bus.
  assign m_axis_tvalid      = (r_count != '0);
  assign m_axis_tdata       = m_axis_tvalid ? w_rd_word[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast       = m_axis_tvalid ? w_rd_word[DATA_WIDTH] : 1'b0;
  assign m_axis_data_count  = 32'(r_count);
  assign stat_frames_merged = r_stat;
  assign status_busy        = r_busy;

  assign s_axis_tready = ((r_state == c_st_payload) && !w_full)
                       ? (LAYER_COUNT'(1) << r_grant) : '0;

endmodule
`default_nettype wire

// File: doc/layers_frame_merger.md
LAYERS_FRAME_MERGER -- requirements
Module: layers_frame_merger

Interface
REQ-001 SHALL have parameter LAYER_COUNT, default 5: number of layer input streams (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width of input and output streams.
REQ-003 SHALL have parameter FIFO_DEPTH, default 1024: output buffer depth in words (power of 2, >=4).
REQ-004 SHALL have port clk_core, input, 1: single clock; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port clk_core_rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have ports s_axis_tdata / tvalid / tlast / tready, input/input/input/output, LAYER_COUNT*DATA_WIDTH / LAYER_COUNT / LAYER_COUNT / LAYER_COUNT: per-layer frame streams, layer i in slice i.
REQ-007 SHALL have ports m_axis_tdata / tvalid / tlast / tready, output/output/output/input, DATA_WIDTH/1/1/1: merged buffered stream.
REQ-008 SHALL have port m_axis_data_count, output, 32: words currently held in buffer.
REQ-009 SHALL have port cfg_layer_enable, input, LAYER_COUNT: arbitration mask.
REQ-010 SHALL have port stat_frames_merged, output, 32: frames fully written to buffer.
REQ-011 SHALL have port status_busy, output, 1: high when FSM not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, HEADER, PAYLOAD.
REQ-013 IDLE: candidates = s_axis_tvalid & cfg_layer_enable; if any, grant the first candidate found searching from (last_grant+1) mod LAYER_COUNT upward with wrap; register grant, go HEADER next cycle.
REQ-014 No candidates in IDLE: stay IDLE, last_grant unchanged.
REQ-015 HEADER: when buffer not full, write one word = grant+1 zero-extended to DATA_WIDTH, tlast=0, go PAYLOAD; while full, hold.
REQ-016 PAYLOAD: s_axis_tready[grant] = buffer not full; all other tready bits 0 in every state.
REQ-017 Each accepted beat SHALL be written to buffer with its tdata and tlast, no reordering, no modification.
REQ-018 Accepted beat with tlast=1: increment stat_frames_merged (32-bit, wraps FFFF_FFFF->0), set last_grant=grant, return IDLE.
REQ-019 Grant SHALL be held for a whole frame; clearing cfg_layer_enable[grant] mid-frame SHALL NOT abort the frame.
REQ-020 Buffer full: write blocked even if a read occurs the same cycle; write and read in same cycle when not full/empty: count unchanged.
REQ-021 m_axis_tvalid = buffer non-empty; word removed on tvalid&tready; first-word latency from accepted input beat to m_axis_tvalid = 1 cycle.
REQ-022 m_axis_data_count SHALL equal writes minus reads, exact every cycle, range 0..FIFO_DEPTH.
REQ-023 status_busy SHALL be registered, high in HEADER and PAYLOAD.

Reset
REQ-024 clk_core_rst high at a clock edge SHALL force: state IDLE, last_grant=LAYER_COUNT-1 (first grant searches from layer 0), buffer empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_data_count=0, stat_frames_merged=0, status_busy=0, all s_axis_tready=0.
REQ-025 Reset mid-frame SHALL discard buffered and partial frame words; no partial frame emitted after reset release.

Configuration
REQ-026 Macro LAYERS_FRAME_MERGER_HEADER_EN defined: HEADER state and header word present as in REQ-015.
REQ-027 Macro undefined: HEADER state absent; IDLE grant goes directly to PAYLOAD; output words are payload only; all other behaviour identical.

Verification
REQ-028 Single frame: layer 2 sends 3 beats A1,A2,A3(last), m_tready=1 -> output 03,A1,A2,A3 with tlast on A3; stat_frames_merged=1.
REQ-029 Round robin: layers 0,1,4 valid continuously with 2-beat frames -> header order 01,02,05,01,02,05; no interleaving within frames.
REQ-030 Mask: cfg_layer_enable=5'b11110, layer 0 valid -> s_axis_tready[0]=0 forever, no header 01 emitted; clearing mask of granted layer mid-frame -> frame completes.
REQ-031 Full: FIFO_DEPTH=4, m_tready=0, 6-beat frame -> data_count stops at 4, tready low; m_tready=1 -> all 7 words delivered in order, count returns 0.
REQ-032 Reset mid-frame after 2 beats -> next cycle m_tvalid=0, count=0, stat=0; next frame from layer 0 starts with header 01.
REQ-033 Macro undefined: repeat REQ-028 -> output A1,A2,A3 only.
